mips_fetch: RTL and testbench

- Instruction fetch stage. It produces the 32-bit instruction words consumed by the main control decoder.
- Owns the PC and issues in-order read requests to instruction memory over a valid/ready request channel.
- Buffers returned words in a small FIFO and presents {instr, pc} to decode over a valid/ready channel.
- Accepts branch/jump redirects and discards wrong-path words.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mips_fetch_fifo.sv | 75 +++++++
 rtl/mips_fetch.sv | 129 ++++++++++++
 tb/tb_mips_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: widths, reset vector,
// primary opcodes and the fetch-to-decode record.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Primary opcode field (instr[31:26]) values understood by the decoder.
  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000
  } opcode_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Small synchronous FIFO with push, pop, flush and occupancy count.
// Used both for fetched words and for the addresses of in-flight requests.
module mips_fetch_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output T              o_data,
  output logic [CW-1:0] o_count
);

  localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_do_push;
  logic          w_do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // A flush wins over push and pop; a full FIFO ignores pushes, an empty one pops.
  assign w_do_push = i_push & ~i_flush & (r_count != FULL_COUNT);
  assign w_do_pop  = i_pop  & ~i_flush & (r_count != '0);

  // Occupancy after this cycle's push/pop; a simultaneous push and pop nets zero.
  always_comb begin
    // NOTE: default assigned first so every path drives w_count_next; a missing branch would infer a latch.
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Pointers and count, cleared by reset or flush.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  // Entry storage, written on accepted pushes only.
  // NOTE: the storage array has no reset; entries are only meaningful below r_count, which is reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mips_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order instruction-memory
// reads under a credit limit, buffers returned words and hands {instr, pc}
// to decode. Redirects flush buffered words and drop wrong-path responses.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  // Instruction memory request channel
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  // Instruction memory response (in order, no backpressure)
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  // Branch/jump redirect from later stages
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  // Decode channel
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_outstanding;   // requests accepted, response not yet seen
  logic [CW-1:0] w_fifo_count;    // words waiting for decode
  logic [CW:0]   w_in_flight;
  logic          w_credit_ok;
  logic          w_req_fire;
  logic          w_resp_ret;
  logic          w_dropping;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_resp_pc;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Credits come from registered occupancy only, so a pop frees its slot
  // one cycle later; redirect and reset gate the request combinationally.
  assign w_in_flight    = {1'b0, w_outstanding} + {1'b0, w_fifo_count};
  assign w_credit_ok    = (w_in_flight < DEPTH_EXT);
  assign imem_req_valid = rst_n & ~redirect_valid & w_credit_ok;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // A response retires the oldest in-flight request; one with nothing
  // outstanding is a protocol violation and is ignored.
  assign w_resp_ret = rst_n & imem_resp_valid & (w_outstanding != '0);
  assign w_dropping = (r_drop_cnt != '0);

  // Only right-path responses reach the decode FIFO; a redirect in the same
  // cycle makes the arriving word wrong-path as well.
  assign w_push = w_resp_ret & ~w_dropping & ~redirect_valid;
  assign w_pop  = out_valid & out_ready;

  assign w_push_entry.instr = imem_resp_data;
  assign w_push_entry.pc    = w_resp_pc;

  // Addresses of issued requests, paired with responses in order. Its
  // occupancy doubles as the outstanding-request count and is never flushed:
  // stale requests keep their credit until their responses come back.
  mips_fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [31:0])
  ) u_pc_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req_fire),
    .i_data  (r_pc),
    .i_pop   (w_resp_ret),
    .i_flush (1'b0),
    .o_data  (w_resp_pc),
    .o_count (w_outstanding)
  );

  // Returned words waiting for decode; emptied on redirect.
  mips_fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  // Decode sees the FIFO head; nothing is offered while reset is asserted.
  assign out_valid = rst_n & (w_fifo_count != '0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  // Program counter: reset vector, redirect target, or next sequential word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= align_word(redirect_pc);
    end else if (w_req_fire) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Wrong-path response counter: a redirect marks every request still in
  // flight after this cycle as stale; each stale response then counts down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_drop_cnt <= w_outstanding - CW'(w_resp_ret);
    end else if (w_resp_ret && w_dropping) begin
      r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch. Instance A uses the defaults (reset PC 0,
// two credits); instance B starts at 0xFFFF_FFF8 with three credits so a
// buffered word and two in-flight requests can coexist. Only one instance
// runs at a time; the other is held in reset.
module tb_mips_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n          [2];
  logic        req_valid      [2];
  logic        req_ready      [2];
  logic [31:0] req_addr       [2];
  logic        resp_valid     [2];
  logic [31:0] resp_data      [2];
  logic        redirect_valid [2];
  logic [31:0] redirect_pc    [2];
  logic        out_valid      [2];
  logic        out_ready      [2];
  logic [31:0] out_instr      [2];
  logic [31:0] out_pc         [2];

  mips_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_req_addr(req_addr[0]),
    .imem_resp_valid(resp_valid[0]), .imem_resp_data(resp_data[0]),
    .redirect_valid(redirect_valid[0]), .redirect_pc(redirect_pc[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_instr(out_instr[0]), .out_pc(out_pc[0])
  );

  mips_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]), .imem_req_addr(req_addr[1]),
    .imem_resp_valid(resp_valid[1]), .imem_resp_data(resp_data[1]),
    .redirect_valid(redirect_valid[1]), .redirect_pc(redirect_pc[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_instr(out_instr[1]), .out_pc(out_pc[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  bit          mem_hold = 1'b0;
  int          n_req    = 0;
  logic [31:0] mem_q [$];   // accepted addresses awaiting a response
  logic [31:0] exp_q [$];   // expected out_pc sequence for the active instance
  logic [31:0] req_log [$];

  logic        s_rv;
  logic        s_ov;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  typedef struct {
    logic        out_ready;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of the active instance: drive the memory response at the start,
  // sample outputs and handshakes on the falling edge, score any pop.
  task automatic cycle();
    logic [31:0] e;
    if (!rst_n[cur]) begin
      mem_q.delete();
      resp_valid[cur] = 1'b0;
      resp_data[cur]  = '0;
    end else if (!mem_hold && mem_q.size() != 0) begin
      resp_valid[cur] = 1'b1;
      resp_data[cur]  = mem_q.pop_front() ^ KEY;
    end else begin
      resp_valid[cur] = 1'b0;
      resp_data[cur]  = '0;
    end
    @(negedge clk);
    s_rv    = req_valid[cur];
    s_addr  = req_addr[cur];
    s_ov    = out_valid[cur];
    s_pc    = out_pc[cur];
    s_instr = out_instr[cur];
    if (s_rv && req_ready[cur]) begin
      mem_q.push_back(s_addr);
      req_log.push_back(s_addr);
      n_req++;
    end
    if (s_ov && out_ready[cur]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc 0x%08h, expected no output", s_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", s_pc, e);
        check("out_instr", s_instr, e ^ KEY);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Hold both instances in reset, then release the selected one.
  task automatic do_reset(input int inst);
    for (int i = 0; i < 2; i++) begin
      rst_n[i]          = 1'b0;
      req_ready[i]      = 1'b0;
      out_ready[i]      = 1'b0;
      redirect_valid[i] = 1'b0;
      redirect_pc[i]    = '0;
      resp_valid[i]     = 1'b0;
      resp_data[i]      = '0;
    end
    cur      = inst;
    mem_hold = 1'b0;
    n_req    = 0;
    mem_q.delete();
    exp_q.delete();
    req_log.delete();
    cycle();
    cycle();
    check("reset_req_valid", 32'(s_rv), 32'd0);
    check("reset_out_valid", 32'(s_ov), 32'd0);
    rst_n[cur] = 1'b1;
  endtask

  // Run until every expected output has appeared or the budget runs out.
  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // ---------------- Straight-line fetch, zero-wait memory (A) -------------
    // Two credits: request, request, pause while the pop frees a slot.
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0010};
    vecs[9] = '{1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0014};

    do_reset(0);
    req_ready[0] = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    for (int i = 0; i < 10; i++) begin
      out_ready[0] = vecs[i].out_ready;
      cycle();
      check($sformatf("sl%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) check($sformatf("sl%0d_req_addr", i), s_addr, vecs[i].exp_addr);
      check($sformatf("sl%0d_out_valid", i), 32'(s_ov), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) check($sformatf("sl%0d_out_pc", i), s_pc, vecs[i].exp_pc);
    end
    check("sl_all_out", 32'(exp_q.size()), 32'd0);

    // ---------------- Backpressure then memory stall (A) -------------------
    do_reset(0);
    req_ready[0] = 1'b1;
    out_ready[0] = 1'b0;
    repeat (6) cycle();
    check("bp_req_count", 32'(n_req), 32'd2);
    check("bp_req0_addr", req_log[0], 32'h0000_0000);
    check("bp_req1_addr", req_log[1], 32'h0000_0004);
    check("bp_req_valid_off", 32'(s_rv), 32'd0);
    check("bp_out_valid", 32'(s_ov), 32'd1);
    check("bp_head_pc", s_pc, 32'h0000_0000);

    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    req_ready[0] = 1'b0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        check("stall0_req_valid", 32'(s_rv), 32'd0);
      end else begin
        check($sformatf("stall%0d_req_valid", i), 32'(s_rv), 32'd1);
        check($sformatf("stall%0d_req_addr", i), s_addr, 32'h0000_0008);
      end
    end
    check("stall_pc_held", 32'(n_req), 32'd2);
    req_ready[0] = 1'b1;
    cycle();
    check("resume_req_valid", 32'(s_rv), 32'd1);
    check("resume_req_addr", s_addr, 32'h0000_0008);
    drain("bp_drain", 40);

    // ---------------- Redirect with a same-cycle response (A) --------------
    do_reset(0);
    req_ready[0] = 1'b1;
    out_ready[0] = 1'b1;
    exp_q = '{32'h200, 32'h204, 32'h208};
    cycle();
    redirect_valid[0] = 1'b1;
    redirect_pc[0]    = 32'h0000_0203;
    cycle();
    check("redir_no_req", 32'(s_rv), 32'd0);
    redirect_valid[0] = 1'b0;
    cycle();
    check("redir_out_valid", 32'(s_ov), 32'd0);
    check("redir_req_valid", 32'(s_rv), 32'd1);
    check("redir_aligned_addr", s_addr, 32'h0000_0200);
    drain("redir_drain", 40);

    // ---------------- PC wrap from 0xFFFF_FFF8 (B) -------------------------
    do_reset(1);
    req_ready[1] = 1'b1;
    out_ready[1] = 1'b1;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    cycle();
    check("wrap_first_addr", s_addr, 32'hFFFF_FFF8);
    drain("wrap_drain", 40);

    // ---------------- Redirect with buffered + two in flight (B) -----------
    do_reset(1);
    req_ready[1] = 1'b1;
    out_ready[1] = 1'b0;
    cycle();
    cycle();
    mem_hold = 1'b1;
    cycle();
    check("flush_req_wrap_addr", s_addr, 32'h0000_0000);
    check("flush_buffered_pc", s_pc, 32'hFFFF_FFF8);
    redirect_valid[1] = 1'b1;
    redirect_pc[1]    = 32'h0000_0100;
    cycle();
    check("flush_no_req", 32'(s_rv), 32'd0);
    redirect_valid[1] = 1'b0;
    mem_hold          = 1'b0;
    out_ready[1]      = 1'b1;
    exp_q = '{32'h100, 32'h104, 32'h108};
    cycle();
    check("flush_out_valid0", 32'(s_ov), 32'd0);
    check("flush_req_addr", s_addr, 32'h0000_0100);
    cycle();
    check("flush_out_valid1", 32'(s_ov), 32'd0);
    drain("flush_drain", 40);

    // ---------------- Reset mid-operation (B) ------------------------------
    do_reset(1);
    req_ready[1] = 1'b1;
    out_ready[1] = 1'b0;
    repeat (3) cycle();
    check("midrst_pre_out_valid", 32'(s_ov), 32'd1);
    rst_n[1] = 1'b0;
    cycle();
    check("midrst_req_valid", 32'(s_rv), 32'd0);
    check("midrst_out_valid", 32'(s_ov), 32'd0);
    rst_n[1]     = 1'b1;
    out_ready[1] = 1'b1;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    cycle();
    check("midrst_restart_addr", s_addr, 32'hFFFF_FFF8);
    check("midrst_no_stale", 32'(s_ov), 32'd0);
    drain("midrst_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
